vpu_alu_si_div_seq: RTL

//  Multi-cycle sequencer for VPU signed-integer division: accepts one operand pair per request,

---
 rtl/vpu_alu_si_div_seq_pkg.sv | 17 +
 rtl/vpu_alu_si_div_seq_if.sv | 31 +++
 rtl/vpu_alu_si_div_seq_step.sv | 39 +++
 rtl/vpu_alu_si_div_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vpu_alu_si_div_seq_pkg.sv
// Shared types and defaults for the sequential signed-integer divider.
// The state enum is shared with anything that inspects the sequencer's progress.
package vpu_alu_si_div_seq_pkg;

    localparam int OPERAND_WIDTH = 32;
    localparam int DIV_BPC       = 1;
    localparam int DIV_TAG_W     = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/vpu_alu_si_div_seq_if.sv
// Request/result handshake bundle between the VPU controller and the divider.
// The master side issues operand pairs and consumes results; the slave side is the divider.
interface vpu_alu_si_div_seq_if
    import vpu_alu_si_div_seq_pkg::*;
#(
    parameter int W     = OPERAND_WIDTH,
    parameter int TAG_W = DIV_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     op_0;
    logic [W-1:0]     op_1;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result_o;
    logic [W-1:0]     rem_o;
    logic [TAG_W-1:0] tag_o;
    logic             dz_o;
    logic             ovf_o;

    modport master (
        output in_valid, op_0, op_1, tag_i, out_ready,
        input  in_ready, out_valid, result_o, rem_o, tag_o, dz_o, ovf_o
    );

    modport slave (
        input  in_valid, op_0, op_1, tag_i, out_ready,
        output in_ready, out_valid, result_o, rem_o, tag_o, dz_o, ovf_o
    );
endinterface

// File: rtl/vpu_alu_si_div_seq_step.sv
// Combinational restoring-division step: retires BPC quotient bits per call.
// Each stage shifts in one dividend bit and subtracts the divisor when it fits.
module vpu_alu_si_div_step
    import vpu_alu_si_div_seq_pkg::*;
#(
    parameter int W   = OPERAND_WIDTH,
    parameter int BPC = DIV_BPC
) (
    input  logic [W:0]     i_rem,
    input  logic [BPC-1:0] i_dvd_bits,
    input  logic [W-1:0]   i_divisor,
    output logic [W:0]     o_rem,
    output logic [BPC-1:0] o_q
);

    for (genvar gi = 0; gi < BPC; gi++) begin : g_step
        logic [W:0]   w_in;
        logic [W:0]   w_out;
        logic [W+1:0] w_shift;
        logic [W+1:0] w_diff;
        logic         w_q;

        if (gi == 0) begin : g_first
            assign w_in = i_rem;
        end else begin : g_next
            assign w_in = g_step[gi-1].w_out;
        end

        // Dividend bits are consumed MSB first, so stage 0 takes the top bit.
        assign w_shift = {w_in, i_dvd_bits[BPC-1-gi]};
        assign w_diff  = w_shift - {2'b00, i_divisor};
        assign w_q     = (w_shift >= {2'b00, i_divisor});
        assign w_out   = (W+1)'(w_q ? w_diff : w_shift);
        assign o_q[BPC-1-gi] = w_q;
    end

    assign o_rem = g_step[BPC-1].w_out;

endmodule

// File: rtl/vpu_alu_si_div_seq.sv
// Multi-cycle signed divider: magnitude restoring division with sign fix-up,
// divide-by-zero / MIN-by-minus-one fast paths, abort and valid/ready result handshake.
module vpu_alu_si_div_seq
    import vpu_alu_si_div_seq_pkg::*;
#(
    parameter int W     = OPERAND_WIDTH,
    parameter int BPC   = DIV_BPC,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_abort,
    output logic                 o_busy,
    vpu_alu_si_div_seq_if.slave  bus
);

    localparam int NSTEP = W / BPC;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    div_state_e       r_state;
    div_state_e       w_state_next;
    logic [W-1:0]     r_op0;
    logic [W-1:0]     r_op1;
    logic [TAG_W-1:0] r_tag;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_div;
    logic [W:0]       r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_result;
    logic [W-1:0]     r_rem_out;
    logic [TAG_W-1:0] r_tag_out;
    logic             r_dz;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_dz;
    logic             w_is_ovf;
    logic             w_cnt_last;
    logic [W-1:0]     w_abs0;
    logic [W-1:0]     w_abs1;
    logic [W:0]       w_step_rem;
    logic [BPC-1:0]   w_step_q;

    assign w_in_ready = (r_state == IDLE) && i_en;
    // An abort on the accepting edge swallows the request.
    assign w_accept   = bus.in_valid && w_in_ready && !i_abort;
    assign w_is_dz    = (r_op1 == '0);
    assign w_is_ovf   = (r_op0 == {1'b1, {(W-1){1'b0}}}) && (r_op1 == '1);
    assign w_cnt_last = (r_cnt == CW'(NSTEP - 1));
    // Negating MIN wraps to itself, which is exactly |MIN| read as unsigned.
    assign w_abs0     = r_op0[W-1] ? -r_op0 : r_op0;
    assign w_abs1     = r_op1[W-1] ? -r_op1 : r_op1;

    vpu_alu_si_div_step #(.W(W), .BPC(BPC)) u_step (
        .i_rem      (r_rem),
        .i_dvd_bits (r_quo[W-1 -: BPC]),
        .i_divisor  (r_div),
        .o_rem      (w_step_rem),
        .o_q        (w_step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = PREP;
            PREP:    w_state_next = (w_is_dz || w_is_ovf) ? DONE : ITER;
            ITER:    if (w_cnt_last) w_state_next = FIX;
            FIX:     w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (i_abort) w_state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op0       <= '0;
            r_op1       <= '0;
            r_tag       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_rem_out   <= '0;
            r_tag_out   <= '0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (i_abort) begin
            if (r_state != IDLE) begin
                r_out_valid <= 1'b0;
                r_dz        <= 1'b0;
                r_ovf       <= 1'b0;
                r_cnt       <= '0;
            end
        end else begin
            if (w_accept) begin
                r_op0 <= bus.op_0;
                r_op1 <= bus.op_1;
                r_tag <= bus.tag_i;
            end
            case (r_state)
                PREP: begin
                    r_quo   <= w_abs0;
                    r_div   <= w_abs1;
                    r_rem   <= '0;
                    r_neg_q <= r_op0[W-1] ^ r_op1[W-1];
                    r_neg_r <= r_op0[W-1];
                    r_cnt   <= '0;
                    if (w_is_dz || w_is_ovf) begin
                        r_result    <= w_is_dz ? '1 : r_op0;
                        r_rem_out   <= w_is_dz ? r_op0 : '0;
                        r_dz        <= w_is_dz;
                        r_ovf       <= !w_is_dz;
                        r_tag_out   <= r_tag;
                        r_out_valid <= 1'b1;
                    end
                end
                ITER: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[W-BPC-1:0], w_step_q};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_result    <= r_neg_q ? -r_quo : r_quo;
                    r_rem_out   <= r_neg_r ? -r_rem[W-1:0] : r_rem[W-1:0];
                    r_dz        <= 1'b0;
                    r_ovf       <= 1'b0;
                    r_tag_out   <= r_tag;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result_o  = r_result;
    assign bus.rem_o     = r_rem_out;
    assign bus.tag_o     = r_tag_out;
    assign bus.dz_o      = r_dz;
    assign bus.ovf_o     = r_ovf;
    assign o_busy        = (r_state != IDLE);

endmodule
